// File: rtl/hmac_tag_verifier.sv
`default_nettype none
// ============================================================================
// Module   : hmac_tag_verifier
// Brief    : Constant-time word-serial HMAC tag checker with fail throttling.
//            Define HMAC_VERIFY_LOCKOUT_EN to enable the timed lockout state.
// Revision : 1.0
// ============================================================================
module hmac_tag_verifier #(
    parameter int TAG_W          = 256,
    parameter int CMP_W          = 32,
    parameter int MAX_FAIL       = 3,
    parameter int LOCK_CYCLES    = 1024,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic                            verify_req,
    input  logic [TAG_W-1:0]                expected_tag,
    output logic                            req_ready,
    output logic                            hmac_go,
    input  logic                            hmac_valid,
    input  logic [TAG_W-1:0]                hmac_in,
    output logic                            result_valid,
    output logic                            result_match,
    output logic                            result_timeout,
    output logic [$clog2(MAX_FAIL+1)-1:0]   fail_count,
    output logic                            locked
);

    localparam int N_WORDS = TAG_W / CMP_W;
    localparam int IDX_W   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam int TOUT_W  = $clog2(TIMEOUT_CYCLES);
    localparam int FC_W    = $clog2(MAX_FAIL + 1);

    localparam logic [IDX_W-1:0]  c_last_idx  = IDX_W'(N_WORDS - 1);
    localparam logic [TOUT_W-1:0] c_tout_last = TOUT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [FC_W-1:0]   c_max_fail  = FC_W'(MAX_FAIL);

    if (((TAG_W % CMP_W) != 0) || (MAX_FAIL < 1) || (LOCK_CYCLES < 1) ||
        (TIMEOUT_CYCLES < 2)) begin : g_param_check
        $error("hmac_tag_verifier: illegal parameter set");
    end

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_CMP  = 3'd2,
        S_DONE = 3'd3,
        S_LOCK = 3'd4
    } state_t;

    state_t             r_state;
    logic [TAG_W-1:0]   r_exp_q;
    logic [TAG_W-1:0]   r_got_q;
    logic [CMP_W-1:0]   r_diff;
    logic [IDX_W-1:0]   r_idx;
    logic [TOUT_W-1:0]  r_tcnt;
    logic               r_req_ready;
    logic               r_hmac_go;
    logic               r_result_valid;
    logic               r_result_match;
    logic               r_result_timeout;
    logic [FC_W-1:0]    r_fail_count;

    logic [CMP_W-1:0]   w_diff_next;
    logic [FC_W-1:0]    w_fail_next;

`ifdef HMAC_VERIFY_LOCKOUT_EN
    localparam int LCNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [LCNT_W-1:0] c_lock_last = LCNT_W'(LOCK_CYCLES - 1);

    logic [LCNT_W-1:0]  r_lcnt;
    logic               r_locked;
`endif

    // Every word is folded into the accumulator; no early exit on mismatch.
    assign w_diff_next = r_diff | (r_exp_q[r_idx*CMP_W +: CMP_W] ^ r_got_q[r_idx*CMP_W +: CMP_W]);

    assign w_fail_next = r_result_match               ? '0         :
                         (r_fail_count == c_max_fail) ? c_max_fail :
                                                        r_fail_count + 1'b1;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state          <= S_IDLE;
            r_exp_q          <= '0;
            r_got_q          <= '0;
            r_diff           <= '0;
            r_idx            <= '0;
            r_tcnt           <= '0;
            r_req_ready      <= 1'b1;
            r_hmac_go        <= 1'b0;
            r_result_valid   <= 1'b0;
            r_result_match   <= 1'b0;
            r_result_timeout <= 1'b0;
            r_fail_count     <= '0;
`ifdef HMAC_VERIFY_LOCKOUT_EN
            r_lcnt           <= '0;
            r_locked         <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (verify_req) begin
                        r_exp_q     <= expected_tag;
                        r_hmac_go   <= 1'b1;
                        r_tcnt      <= '0;
                        r_req_ready <= 1'b0;
                        r_state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (hmac_valid) begin
                        r_got_q   <= hmac_in;
                        r_hmac_go <= 1'b0;
                        r_idx     <= '0;
                        r_diff    <= '0;
                        r_state   <= S_CMP;
                    end else if (r_tcnt == c_tout_last) begin
                        r_hmac_go        <= 1'b0;
                        r_result_valid   <= 1'b1;
                        r_result_match   <= 1'b0;
                        r_result_timeout <= 1'b1;
                        r_state          <= S_DONE;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                S_CMP: begin
                    r_diff <= w_diff_next;
                    if (r_idx == c_last_idx) begin
                        r_result_valid <= 1'b1;
                        r_result_match <= (w_diff_next == '0);
                        r_state        <= S_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_DONE: begin
                    r_result_valid   <= 1'b0;
                    r_result_match   <= 1'b0;
                    r_result_timeout <= 1'b0;
                    r_fail_count     <= w_fail_next;
                    r_exp_q          <= '0;
                    r_got_q          <= '0;
                    r_diff           <= '0;
`ifdef HMAC_VERIFY_LOCKOUT_EN
                    if (w_fail_next == c_max_fail) begin
                        r_lcnt   <= c_lock_last;
                        r_locked <= 1'b1;
                        r_state  <= S_LOCK;
                    end else begin
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
`else
                    r_req_ready <= 1'b1;
                    r_state     <= S_IDLE;
`endif
                end
`ifdef HMAC_VERIFY_LOCKOUT_EN
                S_LOCK: begin
                    if (r_lcnt == '0) begin
                        r_fail_count <= '0;
                        r_locked     <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_state      <= S_IDLE;
                    end else begin
                        r_lcnt <= r_lcnt - 1'b1;
                    end
                end
`endif
                default: begin
                    r_hmac_go   <= 1'b0;
                    r_req_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready      = r_req_ready;
    assign hmac_go        = r_hmac_go;
    assign result_valid   = r_result_valid;
    assign result_match   = r_result_match;
    assign result_timeout = r_result_timeout;
    assign fail_count     = r_fail_count;
`ifdef HMAC_VERIFY_LOCKOUT_EN
    assign locked         = r_locked;
`else
    assign locked         = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hmac_tag_verifier.sv
`default_nettype none
// ============================================================================
// Module   : tb_hmac_tag_verifier
// Brief    : Self-checking bench for hmac_tag_verifier (table, corner, random).
// Revision : 1.0
// ============================================================================
module tb_hmac_tag_verifier;

    localparam int TAG_W          = 256;
    localparam int CMP_W          = 32;
    localparam int MAX_FAIL       = 3;
    localparam int LOCK_CYCLES    = 1024;
    localparam int TIMEOUT_CYCLES = 4096;
    localparam int N_WORDS        = TAG_W / CMP_W;

    logic             CLK          = 1'b0;
    logic             RST          = 1'b1;
    logic             verify_req   = 1'b0;
    logic [TAG_W-1:0] expected_tag = '0;
    logic             hmac_valid   = 1'b0;
    logic [TAG_W-1:0] hmac_in      = '0;
    logic             req_ready;
    logic             hmac_go;
    logic             result_valid;
    logic             result_match;
    logic             result_timeout;
    logic [1:0]       fail_count;
    logic             locked;

    int total    = 0;
    int bad      = 0;
    int model_fc = 0;

    typedef struct {
        string            name;
        logic [TAG_W-1:0] exp_tag;
        logic [TAG_W-1:0] gen_tag;
        int               dly;
        bit               exp_match;
    } vec_t;

    hmac_tag_verifier #(
        .TAG_W          (TAG_W),
        .CMP_W          (CMP_W),
        .MAX_FAIL       (MAX_FAIL),
        .LOCK_CYCLES    (LOCK_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .verify_req     (verify_req),
        .expected_tag   (expected_tag),
        .req_ready      (req_ready),
        .hmac_go        (hmac_go),
        .hmac_valid     (hmac_valid),
        .hmac_in        (hmac_in),
        .result_valid   (result_valid),
        .result_match   (result_match),
        .result_timeout (result_timeout),
        .fail_count     (fail_count),
        .locked         (locked)
    );

    always #5 CLK = ~CLK;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: actual=%0d expected=%0d", nm, act, expv);
        end
    endtask

    function automatic logic [TAG_W-1:0] rnd_tag();
        logic [TAG_W-1:0] t;
        for (int i = 0; i < TAG_W / 32; i++) t[i*32 +: 32] = $urandom;
        return t;
    endfunction

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_ready"},   req_ready,      1);
        chk({nm, "_go"},      hmac_go,        0);
        chk({nm, "_valid"},   result_valid,   0);
        chk({nm, "_match"},   result_match,   0);
        chk({nm, "_timeout"}, result_timeout, 0);
        chk({nm, "_fc"},      fail_count,     0);
        chk({nm, "_locked"},  locked,         0);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1; verify_req = 1'b0; hmac_valid = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        model_fc = 0;
    endtask

    // Counts clock edges from the current negedge until result_valid shows.
    task automatic wait_result(input string nm, input int expect_k);
        int k = 0;
        while (result_valid !== 1'b1 && k < expect_k + 50) begin
            @(negedge CLK);
            k++;
        end
        chk({nm, "_latency"}, k, expect_k);
    endtask

    task automatic finish_result(input string nm, input bit exp_match, input bit exp_to);
        int n = 0;
        chk({nm, "_match"},   result_match,   int'(exp_match));
        chk({nm, "_timeout"}, result_timeout, int'(exp_to));
        chk({nm, "_go_done"}, hmac_go,        0);
        if (exp_match) model_fc = 0;
        else if (model_fc < MAX_FAIL) model_fc++;
        @(negedge CLK);
        chk({nm, "_pulse"}, result_valid, 0);
        chk({nm, "_fc"},    fail_count,   model_fc);
`ifdef HMAC_VERIFY_LOCKOUT_EN
        if (model_fc == MAX_FAIL) begin
            chk({nm, "_lock_ready"}, req_ready, 0);
            while (locked === 1'b1 && n < LOCK_CYCLES + 16) begin
                verify_req   = 1'b1;
                expected_tag = '1;
                n++;
                @(negedge CLK);
            end
            verify_req = 1'b0;
            model_fc   = 0;
            chk({nm, "_lock_len"},    n,          LOCK_CYCLES);
            chk({nm, "_lock_fc_clr"}, fail_count, 0);
            chk({nm, "_lock_ready1"}, req_ready,  1);
            @(negedge CLK);
            chk({nm, "_lock_noqueue"}, hmac_go, 0);
            return;
        end
`endif
        chk({nm, "_locked"}, locked,    0);
        chk({nm, "_ready"},  req_ready, 1);
    endtask

    task automatic run_req(input string nm, input logic [TAG_W-1:0] exp_t,
                           input logic [TAG_W-1:0] gen_t, input int dly, input bit exp_match);
        chk({nm, "_accept_ready"}, req_ready, 1);
        verify_req   = 1'b1;
        expected_tag = exp_t;
        @(negedge CLK);
        verify_req   = 1'b0;
        expected_tag = ~exp_t;
        chk({nm, "_go_high"}, hmac_go, 1);
        repeat (dly) @(negedge CLK);
        hmac_valid = 1'b1;
        hmac_in    = gen_t;
        @(negedge CLK);
        hmac_valid = 1'b0;
        hmac_in    = '0;
        chk({nm, "_go_low"}, hmac_go, 0);
        wait_result(nm, N_WORDS);
        finish_result(nm, exp_match, 1'b0);
    endtask

    initial begin
        vec_t             vecs[6];
        logic [TAG_W-1:0] k_tag;
        logic [TAG_W-1:0] one;
        logic [TAG_W-1:0] a;
        logic [TAG_W-1:0] b;
        int               cnt;

        one   = 1;
        k_tag = rnd_tag();
        vecs[0] = '{"match_k",   k_tag,   k_tag,                     40, 1'b1};
        vecs[1] = '{"flip_b255", k_tag,   k_tag ^ (one << 255),      40, 1'b0};
        vecs[2] = '{"flip_b0",   k_tag,   k_tag ^ one,               40, 1'b0};
        vecs[3] = '{"zeros",     '0,      '0,                         0, 1'b1};
        vecs[4] = '{"ones_zero", '1,      '0,                         3, 1'b0};
        vecs[5] = '{"flip_mid",  k_tag,   k_tag ^ (one << 131),      12, 1'b0};

        repeat (2) @(negedge CLK);
        chk_reset_vals("rst_init");
        RST = 1'b0;
        @(negedge CLK);

        for (int i = 0; i < 6; i++) begin
            do_reset();
            run_req(vecs[i].name, vecs[i].exp_tag, vecs[i].gen_tag, vecs[i].dly, vecs[i].exp_match);
        end

        // Generator never answers.
        do_reset();
        verify_req   = 1'b1;
        expected_tag = k_tag;
        @(negedge CLK);
        verify_req = 1'b0;
        chk("to_go_high", hmac_go, 1);
        wait_result("to", TIMEOUT_CYCLES);
        finish_result("to", 1'b0, 1'b1);

        // Back-to-back failures: lockout or saturation depending on build.
        do_reset();
`ifdef HMAC_VERIFY_LOCKOUT_EN
        for (int i = 0; i < 3; i++) run_req("burst", k_tag, ~k_tag, 2, 1'b0);
`else
        for (int i = 0; i < 5; i++) run_req("burst", k_tag, ~k_tag, 2, 1'b0);
        chk("burst_sat_fc", fail_count, MAX_FAIL);
`endif
        run_req("recover", k_tag, k_tag, 1, 1'b1);

        // Reset while the comparison is on word 4.
        do_reset();
        run_req("pre_rst", k_tag, k_tag ^ one, 0, 1'b0);
        verify_req   = 1'b1;
        expected_tag = k_tag;
        @(negedge CLK);
        verify_req = 1'b0;
        repeat (3) @(negedge CLK);
        hmac_valid = 1'b1;
        hmac_in    = k_tag;
        @(negedge CLK);
        hmac_valid = 1'b0;
        repeat (4) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        chk_reset_vals("rst_mid");
        RST      = 1'b0;
        model_fc = 0;
        cnt      = 0;
        repeat (20) begin
            @(negedge CLK);
            if (result_valid === 1'b1) cnt++;
        end
        chk("rst_mid_no_pulse", cnt, 0);

        for (int i = 0; i < 20; i++) begin
            a = rnd_tag();
            case ($urandom_range(0, 2))
                0:       b = a;
                1:       b = a ^ (one << $urandom_range(0, TAG_W - 1));
                default: b = rnd_tag();
            endcase
            run_req("rand", a, b, int'($urandom_range(0, 25)), a == b);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
